sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised multi-sprite pixel compositor for the VGA XY path. Overlays NUM_SPRITES square sprites of 2^SIZE_LOG2 pixels each onto the background image, with fixed index priority and a transparent colour key. Sprite positions are double-buffered and committed at frame start. Also reports per-frame sprite-to-sprite collisions. Sits between the VGA timing generator (xvga/yvga) and the DAC colour expansion.

## Interface
- NUM_SPRITES, 4: sprite count, 1..8; sprite 0 has highest priority.
- SIZE_LOG2, 2: sprite edge is 2^SIZE_LOG2 pixels, 1..4.
- XW, 8: width of x coordinates.
- YW, 7: width of y coordinates.
- CW, 3: colour width.
- TRANSPARENT, 0: colour key; sprite pixels equal to it show what lies beneath.

Ports:
- VGA_CLK  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  xvga/yvga are an active pixel this cycle.
- xvga  in  XW  current pixel x.
- yvga  in  YW  current pixel y.
- wr_en  in  1  write sprite shadow register.
- wr_idx  in  clog2(NUM_SPRITES), min 1  sprite being written.
- wr_x  in  XW  new sprite x (top-left).
- wr_y  in  YW  new sprite y (top-left).
- wr_show  in  1  new sprite visible flag.
- color  out  CW  composited pixel colour.
- color_valid  out  1  color corresponds to a pixel_valid input two cycles earlier.
- collision  out  NUM_SPRITES  per-sprite collision flags of last completed frame.

## Operation
- Shadow registers (x, y, show per sprite) are written on wr_en.
- Active registers load from shadow on frame_start only. If wr_en and frame_start occur in the same cycle, active takes the pre-write shadow, and the new write lands in shadow for the next frame.
- Hit test, sprite i: show_i && xvga >= x_i && xvga < x_i + 2^SIZE_LOG2 && same for y. Compare in XW+1 / YW+1 bits, so sprites never wrap: x=254, SIZE_LOG2=2 covers x 254..255 only.
- Sprite pixel offset is (xvga - x_i)[SIZE_LOG2-1:0] and (yvga - y_i)[SIZE_LOG2-1:0], fed to sprite i's ROM.
- opaque_i = hit_i && rom_i != TRANSPARENT.
- color is the rom output of the lowest-index opaque sprite; otherwise background_rom output.
- Collision: if two or more opaque_i are set on a valid pixel, OR those bits into the accumulator. On frame_start, collision <= accumulator (including any same-cycle contribution), and the accumulator clears.
- Pixels with pix_valid=0 never contribute to collision. They still produce a colour, with color_valid=0.

## Timing
- Reset: color=0, color_valid=0, collision=0, accumulator=0, all shadow/active x=0, y=0, show=0.
- Pipeline:
  - Stage 1: register pix_valid, xvga, yvga; hit flags and offsets computed from these registers.
  - Stage 2: synchronous ROM read (1 cycle), with hit flags and valid delayed alongside.
  - Output: registered priority mux.
- Latency: pixel presented at cycle N appears on color/color_valid at cycle N+2. Throughput one pixel per clock.
- Position changes become visible for pixels presented at frame_start+1 and later.
- collision updates the cycle after the frame_start pulse and holds for the whole frame.
- reset_n asserted mid-frame clears everything immediately. After release, sprites stay hidden until written and committed.

## Structure
- Package sprite_pkg: colour width, TRANSPARENT default, sprite record typedef (x, y, show), and a clog2-min-1 helper for wr_idx.
- Sub-module sprite_rom_bank: one per sprite, parametrised by SIZE_LOG2, CW, and an init-file name per index; synchronous 1-cycle read. Existing background_rom is instantiated unchanged, fed the stage-1 xvga/yvga.
- Hit logic and priority mux are generate loops within the top.

## Test plan
- Reset, then drive pixels without writing sprites: color equals background_rom(x,y) 2 cycles later, and collision=0.
- Write sprite 0 at (10,20), show=1, then pulse frame_start. Scan row 21: pixels x=10..13 return sprite ROM data, x=9 and x=14 return background, and color_valid tracks pix_valid with 2-cycle delay.
- Sprites 0 and 1 both at (50,50), both opaque: sprite 0 colour wins. Make sprite 0's pixel at offset (1,1) equal TRANSPARENT: that pixel shows sprite 1. After the next frame_start, collision=2'b11 on bits 0,1.
- Write sprite 2 to (100,40) mid-frame: rendering uses the old position until frame_start. Also assert wr_en together with frame_start: the new value is not active until the following frame_start.
- Sprite at x=254, SIZE_LOG2=2: pixels 254,255 hit, and x=0,1 do not hit (no wrap). Also assert reset_n low mid-scan: color=0, color_valid=0, collision=0 within the same cycle, and all sprites hidden afterwards.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, sprite record, index-width helper and sprite pixel patterns
package sprite_pkg;
  localparam int CW_DEF = 3;
  localparam int TRANSPARENT_DEF = 0;
  localparam int POS_W = 16;
  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             show;
  } sprite_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // Sprite 0 keeps offset (1,1) transparent so overlap priority is observable
  function automatic int sprite_pixel(int idx, int ox, int oy);
    return (idx == 0 && ox == 1 && oy == 1) ? 0 : ((idx * 3 + ox + 2 * oy) % 7) + 1;
  endfunction
endpackage

// File: rtl/background_rom.sv
// background_rom: synchronous background image lookup by pixel coordinate
module background_rom #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [CW-1:0] color
);
  always_ff @(posedge clk) color <= CW'(x ^ XW'(y));
endmodule

// File: rtl/sprite_rom_bank.sv
// sprite_rom_bank: one sprite's pixel ROM, synchronous one-cycle read
module sprite_rom_bank import sprite_pkg::*; #(
  parameter int IDX       = 0,
  parameter int SIZE_LOG2 = 2,
  parameter int CW        = 3
) (
  input  logic                 clk,
  input  logic [SIZE_LOG2-1:0] ox,
  input  logic [SIZE_LOG2-1:0] oy,
  output logic [CW-1:0]        data
);
  localparam int E = 2 ** SIZE_LOG2;
  logic [CW-1:0] mem [E*E];
  for (genvar a = 0; a < E * E; a++) begin : g_mem
    assign mem[a] = CW'(sprite_pixel(IDX, a % E, a / E));
  end
  always_ff @(posedge clk) data <= mem[{oy, ox}];
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: overlays prioritised colour-keyed sprites on the background and flags collisions
module sprite_compositor import sprite_pkg::*; #(
  parameter int NUM_SPRITES = 4,
  parameter int SIZE_LOG2   = 2,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int CW          = CW_DEF,
  parameter logic [CW-1:0] TRANSPARENT = CW'(TRANSPARENT_DEF)
) (
  input  logic                             VGA_CLK,
  input  logic                             reset_n,
  input  logic                             frame_start,
  input  logic                             pix_valid,
  input  logic [XW-1:0]                    xvga,
  input  logic [YW-1:0]                    yvga,
  input  logic                             wr_en,
  input  logic [idx_w(NUM_SPRITES)-1:0]    wr_idx,
  input  logic [XW-1:0]                    wr_x,
  input  logic [YW-1:0]                    wr_y,
  input  logic                             wr_show,
  output logic [CW-1:0]                    color,
  output logic                             color_valid,
  output logic [NUM_SPRITES-1:0]           collision
);
  localparam int N = NUM_SPRITES;
  localparam int EW = POS_W + 1;
  localparam logic [POS_W:0] SPAN = EW'(2 ** SIZE_LOG2);
  sprite_t shadow [N];
  sprite_t active [N];
  logic v1, v2;
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  logic [N-1:0] hit1, hit2, opq, acc, contrib;
  logic [N-1:0][CW-1:0] rom;
  logic [CW-1:0] bg, sel;
  logic multi;
  // Active takes the pre-write shadow when a write coincides with frame_start
  always_ff @(posedge VGA_CLK or negedge reset_n)
    if (!reset_n) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      if (frame_start) active <= shadow;
      if (wr_en && int'(wr_idx) < N) shadow[wr_idx] <= '{x: POS_W'(wr_x), y: POS_W'(wr_y), show: wr_show};
    end
  for (genvar i = 0; i < N; i++) begin : g_spr
    logic [POS_W:0] xe, ye, xa, ya;
    logic [SIZE_LOG2-1:0] ox, oy;
    assign xe = EW'(x1);
    assign ye = EW'(y1);
    assign xa = {1'b0, active[i].x};
    assign ya = {1'b0, active[i].y};
    // Widened compare keeps sprites near the right/bottom edge from wrapping
    assign hit1[i] = active[i].show && xe >= xa && xe < xa + SPAN && ye >= ya && ye < ya + SPAN;
    assign ox = SIZE_LOG2'(xe - xa);
    assign oy = SIZE_LOG2'(ye - ya);
    sprite_rom_bank #(.IDX(i), .SIZE_LOG2(SIZE_LOG2), .CW(CW)) u_rom (
      .clk(VGA_CLK), .ox(ox), .oy(oy), .data(rom[i])
    );
    assign opq[i] = hit2[i] && rom[i] != TRANSPARENT;
  end
  background_rom #(.XW(XW), .YW(YW), .CW(CW)) u_bg (
    .clk(VGA_CLK), .x(x1), .y(y1), .color(bg)
  );
  always_comb begin
    sel = bg;
    for (int i = N - 1; i >= 0; i--) sel = opq[i] ? rom[i] : sel;
  end
  assign multi = |(opq & (opq - N'(1)));
  assign contrib = (v2 && multi) ? opq : '0;
  always_ff @(posedge VGA_CLK or negedge reset_n)
    if (!reset_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      v2 <= 1'b0;
      hit2 <= '0;
      color <= '0;
      color_valid <= 1'b0;
      acc <= '0;
      collision <= '0;
    end else begin
      v1 <= pix_valid;
      x1 <= xvga;
      y1 <= yvga;
      v2 <= v1;
      hit2 <= hit1;
      color <= sel;
      color_valid <= v2;
      acc <= frame_start ? '0 : acc | contrib;
      if (frame_start) collision <= acc | contrib;
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed table-driven checks of compositing, priority, commit timing and collisions
module tb_sprite_compositor;
  logic VGA_CLK = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic pix_valid = 1'b0;
  logic [7:0] xvga = '0;
  logic [6:0] yvga = '0;
  logic wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [7:0] wr_x = '0;
  logic [6:0] wr_y = '0;
  logic wr_show = 1'b0;
  logic [2:0] color;
  logic color_valid;
  logic [3:0] collision;
  int errs = 0;
  int checks = 0;
  typedef struct {
    int x;
    int y;
    int v;
    int c;
    int cv;
  } vec_t;
  vec_t tv[$];

  sprite_compositor dut (
    .VGA_CLK(VGA_CLK), .reset_n(reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .xvga(xvga), .yvga(yvga), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_show(wr_show), .color(color), .color_valid(color_valid), .collision(collision)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic cyc();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", n, a, e);
    end
  endtask

  function automatic void add(int x, int y, int v, int c, int cv);
    tv.push_back('{x, y, v, c, cv});
  endfunction

  // Streams the queued pixels back to back; each output appears two edges after capture
  task automatic scan(string tag);
    for (int j = 0; j < tv.size() + 2; j++) begin
      if (j < tv.size()) begin
        xvga = 8'(tv[j].x);
        yvga = 7'(tv[j].y);
        pix_valid = tv[j].v[0];
      end else pix_valid = 1'b0;
      cyc();
      if (j >= 2) begin
        chk($sformatf("%s[%0d] color", tag, j - 2), int'(color), tv[j-2].c);
        chk($sformatf("%s[%0d] valid", tag, j - 2), int'(color_valid), tv[j-2].cv);
      end
    end
    tv.delete();
  endtask

  task automatic wr(int i, int x, int y, int s);
    wr_en = 1'b1;
    wr_idx = 2'(i);
    wr_x = 8'(x);
    wr_y = 7'(y);
    wr_show = s[0];
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset color", int'(color), 0);
    chk("reset valid", int'(color_valid), 0);
    chk("reset collision", int'(collision), 0);
    reset_n = 1'b1;
    cyc();
    add(5, 3, 1, 6, 1);
    add(12, 7, 1, 3, 1);
    add(200, 100, 0, 4, 0);
    add(255, 127, 1, 0, 1);
    scan("bg");
    frame();
    chk("bg collision", int'(collision), 0);
    wr(0, 10, 20, 1);
    frame();
    add(9, 21, 1, 4, 1);
    add(10, 21, 1, 3, 1);
    add(11, 21, 1, 6, 1);
    add(12, 21, 0, 5, 0);
    add(13, 21, 1, 6, 1);
    add(14, 21, 1, 3, 1);
    add(11, 20, 1, 2, 1);
    add(10, 23, 1, 7, 1);
    add(10, 24, 1, 2, 1);
    add(10, 19, 1, 1, 1);
    scan("row21");
    frame();
    chk("single sprite collision", int'(collision), 0);
    wr(0, 50, 50, 1);
    wr(1, 50, 50, 1);
    frame();
    add(50, 50, 1, 1, 1);
    add(51, 51, 1, 7, 1);
    add(52, 51, 1, 5, 1);
    add(53, 53, 1, 3, 1);
    add(54, 50, 1, 4, 1);
    scan("overlap");
    chk("collision held before frame", int'(collision), 0);
    frame();
    chk("overlap collision", int'(collision), 3);
    wr(2, 100, 40, 1);
    add(100, 40, 1, 4, 1);
    scan("midframe old");
    frame();
    chk("collision cleared", int'(collision), 0);
    add(100, 40, 1, 7, 1);
    add(101, 41, 1, 3, 1);
    scan("committed");
    wr_en = 1'b1;
    wr_idx = 2'd2;
    wr_x = 8'd0;
    wr_y = 7'd0;
    wr_show = 1'b1;
    frame_start = 1'b1;
    cyc();
    wr_en = 1'b0;
    frame_start = 1'b0;
    add(0, 0, 1, 0, 1);
    add(100, 40, 1, 7, 1);
    scan("wr+frame");
    frame();
    add(0, 0, 1, 7, 1);
    add(100, 40, 1, 4, 1);
    scan("next frame");
    wr(3, 254, 10, 1);
    frame();
    add(254, 10, 1, 3, 1);
    add(255, 10, 1, 4, 1);
    add(0, 10, 1, 2, 1);
    add(1, 10, 1, 3, 1);
    add(255, 13, 1, 3, 1);
    add(255, 14, 1, 1, 1);
    scan("edge");
    add(50, 50, 1, 1, 1);
    scan("recollide");
    frame();
    chk("recollide collision", int'(collision), 3);
    xvga = 8'd51;
    yvga = 7'd50;
    pix_valid = 1'b1;
    repeat (3) cyc();
    chk("pre-reset color", int'(color), 2);
    chk("pre-reset valid", int'(color_valid), 1);
    #3 reset_n = 1'b0;
    #1;
    chk("async reset color", int'(color), 0);
    chk("async reset valid", int'(color_valid), 0);
    chk("async reset collision", int'(collision), 0);
    pix_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    frame();
    chk("post-reset collision", int'(collision), 0);
    add(51, 50, 1, 1, 1);
    add(254, 10, 1, 4, 1);
    add(0, 0, 1, 0, 1);
    scan("post-reset hidden");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
